// File: rtl/len5_config_pkg.sv
// Global configuration constants shared by the fetch-stage predictors.
package len5_config_pkg;
  localparam int RAS_DEPTH = 8;
endpackage

// File: rtl/return_addr_stack.sv
// Circular return address stack: pushes on predicted calls, pops on predicted returns, overwrites oldest on overflow.
// Updates visible the cycle after the strobe; no handshake, every strobe is accepted.
module return_addr_stack #(
  parameter int DEPTH = len5_config_pkg::RAS_DEPTH,
  parameter int AW    = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic          pop_i,
  output logic [AW-1:0] top_o,
  output logic          valid_o,
  output logic          full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] tos;
  logic [PW:0]   count;
  logic [PW-1:0] tos_inc;
  logic [PW-1:0] tos_dec;

  assign tos_inc = tos + 1'b1;
  assign tos_dec = tos - 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem   <= '{default: '0};
      tos   <= '0;
      count <= '0;
    end else if (flush_i) begin
      tos   <= '0;
      count <= '0;
    end else if (push_i && pop_i) begin
      // Return immediately followed by a call: the new link replaces the top in place.
      mem[tos] <= push_addr_i;
      if (count == '0) count <= (PW+1)'(1);
    end else if (push_i) begin
      tos          <= tos_inc;
      mem[tos_inc] <= push_addr_i;
      if (count != FULL_CNT) count <= count + 1'b1;
    end else if (pop_i && (count != '0)) begin
      tos   <= tos_dec;
      count <= count - 1'b1;
    end
  end

  assign top_o   = mem[tos];
  assign valid_o = (count != '0);
  assign full_o  = (count == FULL_CNT);

endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack: directed scenarios plus random traffic against a bounded-queue stack model.
module tb_return_addr_stack;
  localparam int DEPTH = 8;
  localparam int AW    = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          push;
  logic [AW-1:0] push_addr;
  logic          pop;
  logic [AW-1:0] top;
  logic          valid;
  logic          full;

  int tests = 0;
  int fails = 0;

  // Reference: youngest entry at the back; a push into a full stack drops the front.
  logic [AW-1:0] q [$];

  return_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .push_i      (push),
    .push_addr_i (push_addr),
    .pop_i       (pop),
    .top_o       (top),
    .valid_o     (valid),
    .full_o      (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, AW'(valid), AW'(q.size() != 0));
    chk({tag, ".full"},  AW'(full),  AW'(q.size() == DEPTH));
    if (q.size() != 0) chk({tag, ".top"}, top, q[q.size()-1]);
  endtask

  task automatic step(input logic f, input logic pu, input logic po,
                      input logic [AW-1:0] a, input string tag);
    @(negedge clk);
    flush = f; push = pu; pop = po; push_addr = a;
    @(posedge clk);
    #1;
    flush = 1'b0; push = 1'b0; pop = 1'b0;
    if (f) q.delete();
    else if (pu && po) begin
      if (q.size() == 0) q.push_back(a);
      else q[q.size()-1] = a;
    end else if (pu) begin
      if (q.size() == DEPTH) void'(q.pop_front());
      q.push_back(a);
    end else if (po) begin
      if (q.size() != 0) void'(q.pop_back());
    end
    chk_model(tag);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; push_addr = '0;
    #2;
    chk("reset.top", top, '0);
    chk("reset.valid", AW'(valid), '0);
    chk("reset.full", AW'(full), '0);
    #5 rst = 1'b0;

    // LIFO order
    step(0, 1, 0, 64'h100, "lifo.push");
    step(0, 1, 0, 64'h200, "lifo.push");
    step(0, 1, 0, 64'h300, "lifo.push");
    chk("lifo.top3", top, 64'h300);
    step(0, 0, 1, '0, "lifo.pop");
    chk("lifo.pop1", top, 64'h200);
    step(0, 0, 1, '0, "lifo.pop");
    chk("lifo.pop2", top, 64'h100);
    step(0, 0, 1, '0, "lifo.pop");
    chk("lifo.empty", AW'(valid), '0);

    // Overflow: oldest entry is lost
    for (int i = 0; i < 9; i++) step(0, 1, 0, 64'h1000 + 64'(4*i), "ovf.push");
    chk("ovf.full", AW'(full), 64'd1);
    chk("ovf.top", top, 64'h1020);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 1, '0, "ovf.pop");
      if (k < 8) chk("ovf.popval", top, 64'h1020 - 64'(4*k));
    end
    chk("ovf.empty", AW'(valid), '0);

    // Underflow
    step(0, 0, 1, '0, "unf.pop");
    chk("unf.valid", AW'(valid), '0);
    step(0, 1, 0, 64'hA0, "unf.push");
    chk("unf.top", top, 64'hA0);
    chk("unf.valid1", AW'(valid), 64'd1);
    step(1, 0, 0, '0, "unf.flush");

    // Simultaneous push and pop
    step(0, 1, 0, 64'h40, "sim.push");
    step(0, 1, 1, 64'h80, "sim.both");
    chk("sim.top", top, 64'h80);
    step(0, 0, 1, '0, "sim.pop");
    chk("sim.empty", AW'(valid), '0);
    step(0, 1, 1, 64'h80, "sim.both_empty");
    chk("sim.valid_empty", AW'(valid), 64'd1);
    chk("sim.top_empty", top, 64'h80);
    step(1, 0, 0, '0, "sim.flush");

    // Flush priority
    step(0, 1, 0, 64'h10, "flu.push");
    step(0, 1, 0, 64'h20, "flu.push");
    step(1, 1, 0, 64'h30, "flu.flushpush");
    chk("flu.valid", AW'(valid), '0);
    chk("flu.full", AW'(full), '0);
    step(0, 1, 0, 64'h50, "flu.push2");
    chk("flu.top", top, 64'h50);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      int unsigned op;
      logic [AW-1:0] a;
      op = $urandom_range(0, 19);
      a  = {$urandom, $urandom};
      if (op == 0)       step(1, 0, 0, a, "rnd.flush");
      else if (op <= 8)  step(0, 1, 0, a, "rnd.push");
      else if (op <= 14) step(0, 0, 1, a, "rnd.pop");
      else if (op <= 17) step(0, 1, 1, a, "rnd.both");
      else               step(0, 0, 0, a, "rnd.idle");
    end

    // Asynchronous reset mid-activity, between clock edges
    for (int i = 0; i < 3; i++) step(0, 1, 0, 64'h7000 + 64'(i), "arst.push");
    @(negedge clk);
    push = 1'b1; push_addr = 64'hDEAD;
    #2 rst = 1'b1;
    #1;
    chk("arst.top", top, '0);
    chk("arst.valid", AW'(valid), '0);
    chk("arst.full", AW'(full), '0);
    push = 1'b0;
    q.delete();
    #4 rst = 1'b0;
    step(0, 0, 1, '0, "arst.pop_empty");
    step(0, 1, 0, 64'hBEEF, "arst.push");
    chk("arst.top2", top, 64'hBEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/return_addr_stack.md
# return_addr_stack

Circular return address stack (RAS) for the fetch stage, sized by `RAS_DEPTH` from the global configuration package. It records the link address on every predicted call and returns it as the predicted target on every predicted return, feeding the next-PC selection alongside the g-share predictor and BTB. On overflow it overwrites the oldest entry. Underflow is reported through a valid flag rather than by returning stale data.

## Interface
- `DEPTH`, default `len5_config_pkg::RAS_DEPTH` (8): number of entries. Must be a power of 2 and at least 2.
- `AW`, default 64: address width in bits.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `flush_i`  in  1  empties the stack (pipeline flush or exception).
- `push_i`  in  1  predicted call: push `push_addr_i`.
- `push_addr_i`  in  AW  return address to push (call PC + 4).
- `pop_i`  in  1  predicted return: consume the top entry.
- `top_o`  out  AW  current top-of-stack address (combinational from registers).
- `valid_o`  out  1  stack non-empty; `top_o` is meaningful only when this is 1.
- `full_o`  out  1  count == DEPTH.

## Operation
- State: `mem[DEPTH]` of AW bits; `tos` pointer, log2(DEPTH) bits; `count`, log2(DEPTH)+1 bits, range 0..DEPTH.
- Reset: all `mem` entries = 0, `tos` = 0, `count` = 0. Resulting outputs: `top_o` = 0, `valid_o` = 0, `full_o` = 0.
- `top_o` = `mem[tos]`; `valid_o` = (count != 0); `full_o` = (count == DEPTH).
- Priority per cycle: flush > {push, pop} combination.
- Flush: `tos` = 0 and `count` = 0. `mem` is not cleared. Any push or pop in the same cycle is ignored.
- Push only:
  - `tos` = (tos + 1) mod DEPTH; `mem[tos+1]` = `push_addr_i`.
  - `count` = min(count + 1, DEPTH).
  - When full, the push overwrites the oldest entry, and `count` stays DEPTH.
- Pop only:
  - If count > 0: `tos` = (tos − 1) mod DEPTH, `count` − 1.
  - If count == 0: no state change. This is a silent underflow, with no wrap into stale entries.
- Push and pop in the same cycle (return followed by call, e.g. a coroutine jalr):
  - Replace the top: `mem[tos]` = `push_addr_i` and `tos` is unchanged.
  - `count` = max(count, 1). An empty stack therefore becomes a single entry at the current `tos`.
- Pointer arithmetic wraps modulo DEPTH. `count` saturates at DEPTH and floors at 0.
- There is no handshake: push and pop are single-cycle strobes and are always accepted.

## Timing
- Every update is visible on `top_o`, `valid_o` and `full_o` in the cycle after the strobe. There is no same-cycle bypass of `push_addr_i` to `top_o`.
- `top_o` and `valid_o` are combinational from registers only, with no input-to-output path, so they are safe for the next-PC mux in the same cycle.
- Back-to-back push and pop strobes are supported every cycle.
- Asynchronous reset during activity clears the state immediately. The first edge after reset deassertion behaves as an operation on an empty stack.

## Test plan
- Reset: assert `rst_i` asynchronously between clock edges -> `valid_o` = 0, `top_o` = 0, `full_o` = 0 immediately, with no clock edge required.
- LIFO order: push 0x100, 0x200, 0x300 -> `top_o` = 0x300. Then three pops -> `top_o` reads 0x200, then 0x100, and after the third pop `valid_o` = 0.
- Overflow: push 0x1000 + 4·i for i = 0..8 (9 pushes, DEPTH = 8) -> `full_o` = 1. Then 8 pops return 0x1020 down to 0x1004, and `valid_o` = 0 after the 8th pop. The entry 0x1000 is lost.
- Underflow: pop on an empty stack -> `valid_o` stays 0. Then push 0xA0 -> `top_o` = 0xA0, `valid_o` = 1.
- Simultaneous: push 0x40, then push and pop together with 0x80 -> `top_o` = 0x80, count = 1, and one pop gives `valid_o` = 0. The same push-and-pop on an empty stack -> `valid_o` = 1, `top_o` = 0x80.
- Flush priority: push 0x10, 0x20, then `flush_i` together with push 0x30 -> `valid_o` = 0 and `full_o` = 0. A following push 0x50 -> `top_o` = 0x50.
